spi_regbank_slave: RTL and testbench

SPI_REGBANK_SLAVE -- requirements
Module: spi_regbank_slave

---
 rtl/spi_regbank_slave_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 41 ++++
 rtl/spi_regbank_slave.sv | 201 ++++++++++++++++++++
 tb/tb_spi_regbank_slave.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regbank_slave_pkg.sv
// rtl/spi_regbank_slave_pkg.sv - shared register-map constants for the SPI register-bank slave
package spi_regbank_slave_pkg;

   // Address of read register 0 when the instantiating module does not override it
   localparam int DEFAULT_RD_OFFSET = 64;

   // Frame FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // R/nW occupies the command MSB, directly above the address field
   function automatic int rnw_bit_pos(input int awidth);
      return awidth;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchroniser with rise/fall detection on the synchronised copy
module sync_edge_det #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // Next-state: two resync stages, then one history stage for edge detection
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // All stages reset to the idle level of the line so reset release creates no edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regbank_slave.sv
// rtl/spi_regbank_slave.sv - SPI mode-0 slave giving burst read/write access to a register bank
module spi_regbank_slave
   import spi_regbank_slave_pkg::*;
#(
   parameter int G_DWIDTH    = 16,
   parameter int G_AWIDTH    = 7,
   parameter int G_REG_COUNT = 32,
   parameter int G_RD_OFFSET = DEFAULT_RD_OFFSET
) (
   input  logic                            p_in_clk,
   input  logic                            p_in_rst_n,
   input  logic                            p_in_spi_cs_n,
   input  logic                            p_in_spi_sclk,
   input  logic                            p_in_spi_mosi,
   output logic                            p_out_spi_miso,
   input  logic [G_REG_COUNT*G_DWIDTH-1:0] p_in_reg_rd_data,
   output logic [G_AWIDTH-1:0]             p_out_reg_wr_addr,
   output logic [G_DWIDTH-1:0]             p_out_reg_wr_data,
   output logic                            p_out_reg_wr_en,
   output logic                            p_out_busy,
   output logic                            p_out_frame_err
);

   localparam int CMD_W   = G_AWIDTH + 1;
   localparam int RNW_POS = rnw_bit_pos(G_AWIDTH);
   localparam int MAX_W   = (CMD_W > G_DWIDTH) ? CMD_W : G_DWIDTH;
   localparam int CNT_W   = $clog2(MAX_W + 1);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(G_DWIDTH - 1);

   // Read-register lookup; indices outside the implemented bank read as zero
   function automatic logic [G_DWIDTH-1:0] reg_lookup(
      input logic [G_AWIDTH-1:0]             a,
      input logic [G_REG_COUNT*G_DWIDTH-1:0] vec
   );
      logic [31:0]         idx;
      logic [G_DWIDTH-1:0] res;
      idx = 32'(a) - 32'(G_RD_OFFSET);
      res = '0;
      if (idx < 32'(G_REG_COUNT)) begin
         res = vec[idx*G_DWIDTH +: G_DWIDTH];
      end
      return res;
   endfunction

   logic cs_s, cs_rise, cs_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic sync_unused;

   sync_edge_det #(.RESET_VAL(1'b1)) u_sync_cs (
      .clk(p_in_clk), .rst_n(p_in_rst_n), .d(p_in_spi_cs_n),
      .q(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   sync_edge_det #(.RESET_VAL(1'b0)) u_sync_sclk (
      .clk(p_in_clk), .rst_n(p_in_rst_n), .d(p_in_spi_sclk),
      .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge_det #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk(p_in_clk), .rst_n(p_in_rst_n), .d(p_in_spi_mosi),
      .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign sync_unused = ^{cs_s, sclk_s, mosi_rise, mosi_fall};

   logic [1:0]          state_q,   state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [MAX_W-2:0]    shift_q,   shift_d;
   logic                rnw_q,     rnw_d;
   logic [G_AWIDTH-1:0] addr_q,    addr_d;
   logic [G_DWIDTH-1:0] miso_sr_q, miso_sr_d;
   logic                miso_q,    miso_d;
   logic                wr_en_q,   wr_en_d;
   logic [G_AWIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [G_DWIDTH-1:0] wr_data_q, wr_data_d;
   logic                err_q,     err_d;
   logic [1:0]          settle_q,  settle_d;

   logic [MAX_W-1:0]    shifted;
   logic [G_AWIDTH-1:0] addr_next;
   logic                settled;

   // The CS synchroniser resets high, so a CS held low across reset release would look
   // like a falling edge; CS edges are honoured only once the chain reflects the pin.
   assign settled   = (settle_q == 2'd3);
   assign shifted   = {shift_q, mosi_s};
   assign addr_next = addr_q + 1'b1;

   // Frame decode: command capture, word assembly, write strobes and MISO shifting
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rnw_d     = rnw_q;
      addr_d    = addr_q;
      miso_sr_d = miso_sr_q;
      miso_d    = miso_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = 1'b0;
      settle_d  = settled ? settle_q : settle_q + 2'd1;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall && settled) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               miso_d    = 1'b0;
            end
         end
         ST_CMD: begin
            if (sclk_rise) begin
               shift_d   = shifted[MAX_W-2:0];
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CMD_LAST) begin
                  rnw_d     = shifted[RNW_POS];
                  addr_d    = shifted[G_AWIDTH-1:0];
                  bit_cnt_d = '0;
                  state_d   = ST_DATA;
                  miso_sr_d = shifted[RNW_POS] ?
                              reg_lookup(shifted[G_AWIDTH-1:0], p_in_reg_rd_data) : '0;
               end
            end
         end
         ST_DATA: begin
            if (sclk_rise) begin
               shift_d   = shifted[MAX_W-2:0];
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == WORD_LAST) begin
                  bit_cnt_d = '0;
                  addr_d    = addr_next;
                  if (rnw_q) begin
                     miso_sr_d = reg_lookup(addr_next, p_in_reg_rd_data);
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = shifted[G_DWIDTH-1:0];
                  end
               end
            end else if (sclk_fall && rnw_q) begin
               miso_d    = miso_sr_q[G_DWIDTH-1];
               miso_sr_d = {miso_sr_q[G_DWIDTH-2:0], 1'b0};
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // CS release wins over everything, but only after a same-cycle word completion
      // above has reset the counter, so a just-finished word is not treated as partial.
      if (cs_rise && (state_q != ST_IDLE)) begin
         if (bit_cnt_d != '0) begin
            err_d = 1'b1;
         end
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b1;
      end
   end

   // State registers; reset aborts any frame in flight without a write strobe
   always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
      if (!p_in_rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         rnw_q     <= 1'b0;
         addr_q    <= '0;
         miso_sr_q <= '0;
         miso_q    <= 1'b1;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
         settle_q  <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rnw_q     <= rnw_d;
         addr_q    <= addr_d;
         miso_sr_q <= miso_sr_d;
         miso_q    <= miso_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
         settle_q  <= settle_d;
      end
   end

   assign p_out_spi_miso    = miso_q;
   assign p_out_reg_wr_addr = wr_addr_q;
   assign p_out_reg_wr_data = wr_data_q;
   assign p_out_reg_wr_en   = wr_en_q;
   assign p_out_busy        = (state_q != ST_IDLE);
   assign p_out_frame_err   = err_q;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb/tb_spi_regbank_slave.sv - self-checking bench for spi_regbank_slave
`timescale 1ns/1ps
module tb_spi_regbank_slave;

   localparam int DW = 16;
   localparam int AW = 7;
   localparam int RC = 32;
   localparam int RO = 64;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            cs_n  = 1'b1;
   logic            sclk  = 1'b0;
   logic            mosi  = 1'b0;
   logic [RC*DW-1:0] rd_vec;
   logic            miso;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            wr_en;
   logic            busy;
   logic            frame_err;

   always #5 clk = ~clk;

   spi_regbank_slave dut (
      .p_in_clk          (clk),
      .p_in_rst_n        (rst_n),
      .p_in_spi_cs_n     (cs_n),
      .p_in_spi_sclk     (sclk),
      .p_in_spi_mosi     (mosi),
      .p_out_spi_miso    (miso),
      .p_in_reg_rd_data  (rd_vec),
      .p_out_reg_wr_addr (wr_addr),
      .p_out_reg_wr_data (wr_data),
      .p_out_reg_wr_en   (wr_en),
      .p_out_busy        (busy),
      .p_out_frame_err   (frame_err)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   int            errors = 0;
   int            checks = 0;
   wr_t           exp_q[$];
   logic [DW-1:0] regs[RC];
   logic [DW-1:0] tx_words[8];
   logic [DW-1:0] rx_words[8];
   int            wr_seen  = 0;
   int            err_seen = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic [DW-1:0] last_wr_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: register bank contents as seen through the read window
   function automatic logic [DW-1:0] model_read(input int a);
      if (a >= RO && a < RO + RC) return regs[a - RO];
      return '0;
   endfunction

   // Model: a write burst of n words lands at consecutive addresses modulo 2^AW
   task automatic expect_write(input logic [7:0] cmd, input int n);
      wr_t e;
      for (int i = 0; i < n; i++) begin
         e.a = AW'((int'(cmd[6:0]) + i) % 128);
         e.d = tx_words[i];
         exp_q.push_back(e);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},    32'(miso),      32'd1);
      check({tag, "_wr_en"},   32'(wr_en),     32'd0);
      check({tag, "_busy"},    32'(busy),      32'd0);
      check({tag, "_err"},     32'(frame_err), 32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr),   32'd0);
      check({tag, "_wr_data"}, 32'(wr_data),   32'd0);
   endtask

   // One SPI master frame. mode 0: normal; 1: CS released together with the last SCLK rise;
   // 2: reset pulsed after the last listed bit, then 4 more bits clocked with CS still low.
   task automatic spi_xfer(input logic [7:0] cmd, input int nbits, input int mode);
      logic [DW-1:0] w;
      int            k;
      for (int i = 0; i < 8; i++) rx_words[i] = '0;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i < 8) begin
            mosi = cmd[7-i];
         end else begin
            k    = (i - 8) / 16;
            w    = tx_words[k];
            mosi = w[15 - ((i - 8) % 16)];
         end
         repeat (4) @(negedge clk);
         if (mode == 1 && i == nbits - 1) cs_n = 1'b1;
         sclk = 1'b1;
         if (i >= 8) begin
            k = (i - 8) / 16;
            rx_words[k] = {rx_words[k][14:0], miso};
         end
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         if (mode == 0 && i == 9) check("busy_mid_frame", 32'(busy), 32'd1);
      end
      if (mode == 2) begin
         rst_n = 1'b0;
         repeat (3) @(negedge clk);
         check_reset_outputs("rst_mid");
         rst_n = 1'b1;
         for (int j = 0; j < 4; j++) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
         end
         check("rst_no_restart_busy", 32'(busy), 32'd0);
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic do_read(input string tag, input logic [7:0] cmd, input int n);
      int w0;
      w0 = wr_seen;
      spi_xfer(cmd, 8 + 16 * n, 0);
      for (int i = 0; i < n; i++) begin
         check({tag, "_word"}, 32'(rx_words[i]),
               32'(model_read((int'(cmd[6:0]) + i) % 128)));
      end
      check({tag, "_no_wr"}, 32'(wr_seen - w0), 32'd0);
   endtask

   // Compare process: every write strobe must match the head of the model queue
   initial begin
      wr_t e;
      logic prev_wr = 1'b0;
      logic prev_er = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (wr_en) begin
               wr_seen++;
               last_wr_addr = wr_addr;
               last_wr_data = wr_data;
               check("wr_en_single_cycle", 32'(prev_wr), 32'd0);
               if (exp_q.size() == 0) begin
                  check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 32'(wr_addr), 32'(e.a));
                  check("wr_data", 32'(wr_data), 32'(e.d));
               end
            end
            if (frame_err) begin
               err_seen++;
               check("err_single_cycle", 32'(prev_er), 32'd0);
            end
         end
         prev_wr = wr_en;
         prev_er = frame_err;
      end
   end

   initial begin
      int w0, e0;
      for (int k = 0; k < RC; k++) begin
         regs[k] = DW'(k * 16'h0111) ^ 16'hC35A;
      end
      regs[0] = 16'hBEEF;
      regs[1] = 16'h1234;
      for (int k = 0; k < RC; k++) rd_vec[k*DW +: DW] = regs[k];

      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single write
      tx_words[0] = 16'hA5C3;
      w0 = wr_seen; e0 = err_seen;
      expect_write(8'h05, 1);
      spi_xfer(8'h05, 24, 0);
      check("t1_wr_count", 32'(wr_seen - w0), 32'd1);
      check("t1_addr", 32'(last_wr_addr), 32'h05);
      check("t1_data", 32'(last_wr_data), 32'hA5C3);
      check("t1_miso_zero", 32'(rx_words[0]), 32'd0);
      check("t1_no_err", 32'(err_seen - e0), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);
      check("t1_miso_idle", 32'(miso), 32'd1);

      // Burst write wrapping the address
      tx_words[0] = 16'h1111; tx_words[1] = 16'h2222; tx_words[2] = 16'h3333;
      w0 = wr_seen;
      expect_write(8'h7F, 3);
      spi_xfer(8'h7F, 8 + 48, 0);
      check("t2_wr_count", 32'(wr_seen - w0), 32'd3);
      check("t2_last_addr", 32'(last_wr_addr), 32'h01);
      check("t2_last_data", 32'(last_wr_data), 32'h3333);
      check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

      // Reads: first registers, just past the bank, last register, wrapping high addresses
      do_read("t3", 8'hC0, 2);
      check("t3_word0_lit", 32'(rx_words[0]), 32'hBEEF);
      check("t3_word1_lit", 32'(rx_words[1]), 32'h1234);
      do_read("t4", 8'hE0, 1);
      check("t4_oob_lit", 32'(rx_words[0]), 32'h0000);
      do_read("t4b", 8'hDF, 2);
      check("t4b_last_lit", 32'(rx_words[0]), 32'(DW'(31 * 16'h0111) ^ 16'hC35A));
      do_read("t4c", 8'hFF, 2);

      // Truncated data word, then a clean frame
      tx_words[0] = 16'hFFFF;
      w0 = wr_seen; e0 = err_seen;
      spi_xfer(8'h05, 8 + 5, 0);
      check("t5_err", 32'(err_seen - e0), 32'd1);
      check("t5_no_wr", 32'(wr_seen - w0), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      tx_words[0] = 16'h0F0F;
      w0 = wr_seen; e0 = err_seen;
      expect_write(8'h10, 1);
      spi_xfer(8'h10, 24, 0);
      check("t5b_wr", 32'(wr_seen - w0), 32'd1);
      check("t5b_data", 32'(last_wr_data), 32'h0F0F);
      check("t5b_no_err", 32'(err_seen - e0), 32'd0);

      // Truncated command and command-only frame
      e0 = err_seen; w0 = wr_seen;
      spi_xfer(8'h05, 3, 0);
      check("t6_err", 32'(err_seen - e0), 32'd1);
      e0 = err_seen;
      spi_xfer(8'h05, 8, 0);
      check("t7_no_err", 32'(err_seen - e0), 32'd0);
      check("t7_no_wr", 32'(wr_seen - w0), 32'd0);

      // CS released in the same cycle as the word-completing edge
      tx_words[0] = 16'h8001;
      w0 = wr_seen; e0 = err_seen;
      expect_write(8'h20, 1);
      spi_xfer(8'h20, 24, 1);
      check("t8_wr", 32'(wr_seen - w0), 32'd1);
      check("t8_addr", 32'(last_wr_addr), 32'h20);
      check("t8_no_err", 32'(err_seen - e0), 32'd0);

      // Reset pulsed mid-word, then a fresh frame
      tx_words[0] = 16'hFFFF;
      w0 = wr_seen; e0 = err_seen;
      spi_xfer(8'h05, 8 + 5, 2);
      check("t9_no_wr", 32'(wr_seen - w0), 32'd0);
      check("t9_no_err", 32'(err_seen - e0), 32'd0);
      tx_words[0] = 16'h5A5A;
      expect_write(8'h33, 1);
      spi_xfer(8'h33, 24, 0);
      check("t9b_wr", 32'(wr_seen - w0), 32'd1);
      check("t9b_addr", 32'(last_wr_addr), 32'h33);
      check("t9b_data", 32'(last_wr_data), 32'h5A5A);
      check("final_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
